// File: rtl/dec_pkg.sv
// Shared definitions for the decode transaction sequencer:
//   state_t    - sequencer states
//   MODE_*     - codeword size codes on the mode input
//   NOF_*      - error-count codes from the syndrome unit
//   SYND_W     - syndrome width
package dec_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYND_REQ  = 3'd1,
        SYND_WAIT = 3'd2,
        FIX       = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [1:0] MODE_SMALL   = 2'b00;
    localparam logic [1:0] MODE_MEDIUM  = 2'b01;
    localparam logic [1:0] MODE_LARGE   = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam logic [1:0] NOF_NONE   = 2'b00;
    localparam logic [1:0] NOF_SINGLE = 2'b01;
    localparam logic [1:0] NOF_MULTI  = 2'b10;

    localparam int SYND_W = 5;

endpackage

// File: rtl/dec_timeout_cnt.sv
// Syndrome-wait timeout counter.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - synchronous clear to zero (has priority over en)
//   en        - count up by one
//   tc        - terminal count: count == TIMEOUT-1
module dec_timeout_cnt #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/decode_controller.sv
// Sequencer for one decode transaction: latch codeword, request a syndrome,
// wait (with timeout), present the result to the error-fix stage for one
// cycle, then pulse done with the saturated error classification.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   start, mode, cw_in            - transaction request (sampled in IDLE)
//   busy                          - state != IDLE
//   synd_req, synd_cw             - request/codeword to the syndrome unit
//   synd_valid, synd_s, synd_nof  - syndrome unit result
//   fix_s, fix_nof, fix_small,
//   fix_medium, fix_data          - operands for the error-fix stage
//   done, nof_out                 - completion pulse and classification
//   err_timeout, err_mode         - error pulses
//
// state     | meaning
// IDLE      | waiting for start
// SYND_REQ  | pulse synd_req, clear timeout counter
// SYND_WAIT | waiting for synd_valid or timeout
// FIX       | fix_* stable while error-fix stage registers
// DONE      | pulse done with nof_out
module decode_controller
    import dec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64,
    parameter int TO_W       = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] cw_in,
    output logic                  busy,
    output logic                  synd_req,
    output logic [DATA_WIDTH-1:0] synd_cw,
    input  logic                  synd_valid,
    input  logic [SYND_W-1:0]     synd_s,
    input  logic [1:0]            synd_nof,
    output logic [SYND_W-1:0]     fix_s,
    output logic [1:0]            fix_nof,
    output logic                  fix_small,
    output logic                  fix_medium,
    output logic [DATA_WIDTH-1:0] fix_data,
    output logic                  done,
    output logic [1:0]            nof_out,
    output logic                  err_timeout,
    output logic                  err_mode
);

    state_t     state;
    logic [1:0] mode_q;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_tc;

    // Counter runs only on wait cycles without a result, so valid on the
    // terminal cycle wins over the timeout.
    assign cnt_clr = (state == SYND_REQ);
    assign cnt_en  = (state == SYND_WAIT) && !synd_valid;

    dec_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mode_q      <= MODE_SMALL;
            busy        <= 1'b0;
            synd_req    <= 1'b0;
            synd_cw     <= '0;
            fix_s       <= '0;
            fix_nof     <= NOF_NONE;
            fix_small   <= 1'b0;
            fix_medium  <= 1'b0;
            fix_data    <= '0;
            done        <= 1'b0;
            nof_out     <= NOF_NONE;
            err_timeout <= 1'b0;
            err_mode    <= 1'b0;
        end else begin
            synd_req    <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_mode    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == MODE_ILLEGAL) begin
                            err_mode <= 1'b1;
                        end else begin
                            mode_q   <= mode;
                            synd_cw  <= cw_in;
                            fix_data <= cw_in;
                            busy     <= 1'b1;
                            state    <= SYND_REQ;
                        end
                    end
                end
                SYND_REQ: begin
                    synd_req <= 1'b1;
                    state    <= SYND_WAIT;
                end
                SYND_WAIT: begin
                    if (synd_valid) begin
                        fix_s      <= synd_s;
                        fix_nof    <= synd_nof;
                        fix_small  <= (mode_q == MODE_SMALL);
                        fix_medium <= (mode_q == MODE_MEDIUM);
                        state      <= FIX;
                    end else if (cnt_tc) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                FIX: begin
                    state <= DONE;
                end
                DONE: begin
                    done    <= 1'b1;
                    nof_out <= (fix_nof == 2'b11) ? NOF_MULTI : fix_nof;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_controller.sv
// Directed, table-driven bench for decode_controller.
module tb_decode_controller;

    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [DW-1:0] cw_in;
    logic          busy;
    logic          synd_req;
    logic [DW-1:0] synd_cw;
    logic          synd_valid;
    logic [4:0]    synd_s;
    logic [1:0]    synd_nof;
    logic [4:0]    fix_s;
    logic [1:0]    fix_nof;
    logic          fix_small;
    logic          fix_medium;
    logic [DW-1:0] fix_data;
    logic          done;
    logic [1:0]    nof_out;
    logic          err_timeout;
    logic          err_mode;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_controller #(.DATA_WIDTH(DW), .TIMEOUT(TO), .TO_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .cw_in       (cw_in),
        .busy        (busy),
        .synd_req    (synd_req),
        .synd_cw     (synd_cw),
        .synd_valid  (synd_valid),
        .synd_s      (synd_s),
        .synd_nof    (synd_nof),
        .fix_s       (fix_s),
        .fix_nof     (fix_nof),
        .fix_small   (fix_small),
        .fix_medium  (fix_medium),
        .fix_data    (fix_data),
        .done        (done),
        .nof_out     (nof_out),
        .err_timeout (err_timeout),
        .err_mode    (err_mode)
    );

    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] cw;
        logic [4:0]    s;
        logic [1:0]    nof;
        int            wait_n;
        logic          exp_small;
        logic          exp_medium;
        logic [1:0]    exp_nof;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".synd_req"}, 32'(synd_req), 0);
        check({tag, ".synd_cw"}, synd_cw, 0);
        check({tag, ".fix_s"}, 32'(fix_s), 0);
        check({tag, ".fix_nof"}, 32'(fix_nof), 0);
        check({tag, ".fix_small"}, 32'(fix_small), 0);
        check({tag, ".fix_medium"}, 32'(fix_medium), 0);
        check({tag, ".fix_data"}, fix_data, 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".nof_out"}, 32'(nof_out), 0);
        check({tag, ".err_timeout"}, 32'(err_timeout), 0);
        check({tag, ".err_mode"}, 32'(err_mode), 0);
    endtask

    // Full transaction; done is checked low at edge 3+wait and high at 4+wait.
    task automatic run_txn(input vec_t v, input string tag);
        mode  = v.mode;
        cw_in = v.cw;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".busy_c0"}, 32'(busy), 1);
        check({tag, ".synd_req_c0"}, 32'(synd_req), 0);
        tick();
        check({tag, ".synd_req_c1"}, 32'(synd_req), 1);
        check({tag, ".synd_cw"}, synd_cw, v.cw);
        for (int i = 0; i < v.wait_n; i++) tick();
        synd_valid = 1'b1;
        synd_s     = v.s;
        synd_nof   = v.nof;
        tick();
        synd_valid = 1'b0;
        check({tag, ".err_timeout"}, 32'(err_timeout), 0);
        check({tag, ".fix_s"}, 32'(fix_s), 32'(v.s));
        check({tag, ".fix_nof"}, 32'(fix_nof), 32'(v.nof));
        check({tag, ".fix_small"}, 32'(fix_small), 32'(v.exp_small));
        check({tag, ".fix_medium"}, 32'(fix_medium), 32'(v.exp_medium));
        check({tag, ".fix_data"}, fix_data, v.cw);
        tick();
        check({tag, ".done_early"}, 32'(done), 0);
        tick();
        check({tag, ".done"}, 32'(done), 1);
        check({tag, ".nof_out"}, 32'(nof_out), 32'(v.exp_nof));
        check({tag, ".busy_done"}, 32'(busy), 0);
        tick();
        check({tag, ".done_pulse"}, 32'(done), 0);
        check({tag, ".fix_data_held"}, fix_data, v.cw);
    endtask

    initial begin
        int   n;
        logic saw_done;
        vec_t v;

        vecs[0] = '{2'b00, 32'h0000_00A5, 5'b00011, 2'b01, 0,      1'b1, 1'b0, 2'b01};
        vecs[1] = '{2'b10, 32'hDEAD_BEEF, 5'b11111, 2'b11, 0,      1'b0, 1'b0, 2'b10};
        vecs[2] = '{2'b01, 32'h1234_5678, 5'b01010, 2'b00, 3,      1'b0, 1'b1, 2'b00};
        vecs[3] = '{2'b00, 32'hFFFF_FFFF, 5'b10000, 2'b10, TO - 1, 1'b1, 1'b0, 2'b10};
        vecs[4] = '{2'b10, 32'h0000_BEEF, 5'b00010, 2'b01, 1,      1'b0, 1'b0, 2'b01};

        rst        = 1'b0;
        start      = 1'b0;
        mode       = 2'b00;
        cw_in      = '0;
        synd_valid = 1'b0;
        synd_s     = '0;
        synd_nof   = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset with outputs preloaded from the previous run.
        rst = 1'b0;
        #1;
        check_all_zero("reset_preload");
        tick();
        rst = 1'b1;
        tick();

        // Illegal mode.
        mode  = 2'b11;
        cw_in = 32'h0BAD_0BAD;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_mode.pulse", 32'(err_mode), 1);
        check("err_mode.busy", 32'(busy), 0);
        check("err_mode.synd_req", 32'(synd_req), 0);
        tick();
        check("err_mode.clear", 32'(err_mode), 0);
        check("err_mode.busy2", 32'(busy), 0);
        check("err_mode.synd_cw", synd_cw, 0);

        // Timeout.
        mode  = 2'b01;
        cw_in = 32'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 0;
        saw_done = 1'b0;
        while (err_timeout !== 1'b1 && n < 4 * TO) begin
            tick();
            n++;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("timeout.pulse", 32'(err_timeout), 1);
        check("timeout.cycles", n, TO);
        check("timeout.no_done", 32'(saw_done), 0);
        check("timeout.busy", 32'(busy), 0);
        tick();
        check("timeout.clear", 32'(err_timeout), 0);
        check("timeout.done", 32'(done), 0);

        // Start during SYND_WAIT is ignored.
        mode  = 2'b00;
        cw_in = 32'h1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mode  = 2'b01;
        cw_in = 32'h2222;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        synd_valid = 1'b1;
        synd_s     = 5'd5;
        synd_nof   = 2'b00;
        tick();
        synd_valid = 1'b0;
        check("busy_start.fix_data", fix_data, 32'h1111);
        check("busy_start.synd_cw", synd_cw, 32'h1111);
        check("busy_start.fix_small", 32'(fix_small), 1);
        tick();
        tick();
        check("busy_start.done", 32'(done), 1);
        tick();
        check("busy_start.idle", 32'(busy), 0);

        // synd_valid in IDLE is ignored.
        synd_valid = 1'b1;
        synd_s     = 5'h1F;
        synd_nof   = 2'b10;
        tick();
        tick();
        synd_valid = 1'b0;
        check("idle_valid.busy", 32'(busy), 0);
        check("idle_valid.fix_s", 32'(fix_s), 5);
        check("idle_valid.fix_nof", 32'(fix_nof), 0);
        check("idle_valid.done", 32'(done), 0);

        // Reset during FIX, then a fresh run.
        mode  = 2'b01;
        cw_in = 32'hCAFE;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        synd_valid = 1'b1;
        synd_s     = 5'd7;
        synd_nof   = 2'b01;
        tick();
        synd_valid = 1'b0;
        check("abort.in_fix", 32'(fix_s), 7);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        #1;
        rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort.no_done", 32'(saw_done), 0);
        v = vecs[4];
        run_txn(v, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_controller.md
Name: decode_controller

Overview:
- Sequencer for one decode transaction in the error-correction decoder.
- Accepts a codeword plus a size mode, requests a syndrome from the syndrome unit, and waits for the result with a timeout.
- Drives the error-fix stage (syndrome, error count, Small/Medium select, data), then reports done and the error classification.
- Sits between the bus-side register/control logic and the syndrome/error-fix datapath.

Parameters:
- DATA_WIDTH, 32: codeword and data width; matches the error-fix stage.
- TIMEOUT, 64: cycles allowed in SYND_WAIT before abort; must be >= 2.
- TO_W, 7: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  2  codeword size: 00 small, 01 medium, 10 large, 11 illegal.
- cw_in  in  DATA_WIDTH  codeword, sampled with start.
- busy  out  1  high whenever state != IDLE.
- synd_req  out  1  one-cycle request to the syndrome unit.
- synd_cw  out  DATA_WIDTH  latched codeword presented to the syndrome unit.
- synd_valid  in  1  syndrome result valid; honoured only in SYND_WAIT.
- synd_s  in  5  syndrome value.
- synd_nof  in  2  error count: 00 none, 01 single, 10/11 multiple.
- fix_s  out  5  syndrome to the error-fix stage.
- fix_nof  out  2  error count to the error-fix stage.
- fix_small  out  1  small-mode select.
- fix_medium  out  1  medium-mode select.
- fix_data  out  DATA_WIDTH  codeword to the error-fix stage.
- done  out  1  one-cycle completion pulse.
- nof_out  out  2  final classification; valid while done=1.
- err_timeout  out  1  one-cycle pulse on syndrome timeout.
- err_mode  out  1  one-cycle pulse on illegal mode at start.

Behaviour:
- Reset: rst asynchronous, active-low; clock clk. On reset, state goes to IDLE and every output is 0, including the fix_* and synd_cw registers.
- Reset mid-transaction: the transaction is abandoned silently; no done or error pulse.
- All outputs are registered. There is no combinational path from any input to any output.
- IDLE:
  - start=1 and mode!=11: latch mode and cw_in into synd_cw/fix_data; go to SYND_REQ.
  - start=1 and mode=11: err_mode=1 for one cycle; stay in IDLE.
  - start while busy is ignored and not queued.
- SYND_REQ: synd_req=1 for exactly one cycle; clear the timeout counter; go to SYND_WAIT.
- SYND_WAIT:
  - synd_valid=1: latch fix_s<=synd_s and fix_nof<=synd_nof; drive fix_small/fix_medium from the latched mode; go to FIX.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with synd_valid=0: err_timeout=1 for one cycle; go to IDLE.
  - synd_valid in the same cycle as the final count: valid wins, no timeout.
  - synd_valid outside SYND_WAIT is ignored.
- FIX: fix_* are held stable for one full cycle; the error-fix stage registers its output at the end of this cycle. Go to DONE.
- DONE:
  - done=1 for one cycle.
  - nof_out = fix_nof, except 11 is saturated to 10.
  - Go to IDLE.
- fix_* hold their values until the next latch; they are not cleared at done.
- Mode decode:
  - 00: fix_small=1, fix_medium=0.
  - 01: fix_small=0, fix_medium=1.
  - 10: both 0.
- Latency: with start accepted at edge 0 and synd_valid in the first SYND_WAIT cycle, done is high in cycle 4 (edge 4). Every extra wait cycle adds 1.
- Multiple-error results are still routed through FIX; only nof_out=10 flags them as uncorrectable.

Decomposition:
- Shared package dec_pkg holds:
  - state enum: IDLE, SYND_REQ, SYND_WAIT, FIX, DONE.
  - mode codes: MODE_SMALL, MODE_MEDIUM, MODE_LARGE, MODE_ILLEGAL.
  - NOF codes: NOF_NONE, NOF_SINGLE, NOF_MULTI.
  - syndrome width constant: 5.
- One sub-module, dec_timeout_cnt: a clearable, enabled counter with a terminal-count flag at TIMEOUT-1.

Test Plan:
- Reset with outputs preloaded from a prior run -> all outputs 0, busy=0, state IDLE.
- start, mode=00, cw_in=0x000000A5; synd_valid in the first wait cycle with s=00011, nof=01 -> synd_req pulse in cycle 1; fix_small=1, fix_s=00011, fix_data=0xA5; done in cycle 4; nof_out=01.
- start, mode=10; synd_nof=11 -> fix_small=fix_medium=0; done pulse; nof_out=10.
- start, mode=01; synd_valid never asserted -> err_timeout pulse exactly TIMEOUT cycles after entering SYND_WAIT; no done; busy=0 afterwards.
- Edge cases:
  - start with mode=11 -> err_mode pulse, busy stays 0.
  - start during SYND_WAIT -> ignored; the latched cw is unchanged.
  - synd_valid in IDLE -> ignored.
- rst asserted during FIX, then a new start -> no done from the aborted run; the new run completes with correct nof_out.
